arbitro_leds: RTL and testbench
===============================

# arbitro_leds

Controller that shares the green/red LED toggle state machine between two pushbutton requesters. Each raw button is synchronized, debounced and edge-detected into a sticky request. A round-robin arbiter then grants at most one toggle at a time, followed by a programmable hold-off window. It sits between the board KEY inputs and the LEDG/LEDR outputs, replacing direct button-to-FSM wiring.

## Interface
- DEBOUNCE_CICLOS, 4: consecutive cycles a synchronized input must differ from its debounced level before the level updates; minimum 1.
- HOLDOFF_CICLOS, 3: cycles after a grant during which no new grant is issued; minimum 1.
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- botao  input  2  raw button levels, active-high, asynchronous to clock.
- ledVerde  output  1  high when the LED state is VERDE.
- ledVermelho  output  1  high when the LED state is VERMELHO.
- concedido  output  2  one-hot, one-cycle pulse naming the channel whose request was just served.
- pendente  output  2  sticky request flags, one per channel.
- ocupado  output  1  high while the hold-off is active.

## Operation
- **Synchronizer:** two flops per channel, reset to 0.
- **Debounce:**
  - Per-channel counter and debounced level `nivel[i]`, both reset to 0.
  - While sync[i] differs from nivel[i], the counter increments.
  - When it would reach DEBOUNCE_CICLOS, nivel[i] takes sync[i] and the counter clears.
  - Any cycle with sync[i] equal to nivel[i] clears the counter. A glitch lasting fewer than DEBOUNCE_CICLOS cycles is ignored.
- **Request:**
  - A rising edge of nivel[i] sets pendente[i] on the next edge.
  - Further edges while pendente[i] is set collapse into the same request.
  - Falling edges are ignored.
- **Arbiter:**
  - Hold-off counter `espera`, reset to 0; ocupado = (espera != 0).
  - At a clock edge with espera == 0 and pendente != 0, grant one channel:
    - If only one channel is pending, grant it.
    - If both are pending, grant the channel != `ultimo`.
    - `ultimo` resets to 1, so channel 0 wins the first tie.
  - The grant edge does all of the following together:
    - concedido[g] = 1 for one cycle.
    - Clear pendente[g].
    - `ultimo` = g.
    - Toggle the LED state.
    - Load espera with HOLDOFF_CICLOS.
  - espera decrements each cycle while nonzero.
  - A request arriving during hold-off stays pending and is never dropped.
- **LED state machine:**
  - States VERDE (ledVerde=1, ledVermelho=0) and VERMELHO (ledVerde=0, ledVermelho=1).
  - Transition occurs only on a grant: VERDE to VERMELHO, VERMELHO to VERDE.
  - The outputs are never both high and never both low.
- **Simultaneous events:** if a new rising edge on channel i coincides with the grant clearing pendente[i], the set wins and pendente[i] remains 1.

## Timing
- Reset values:
  - ledVerde = 1, ledVermelho = 0.
  - concedido = 00, pendente = 00, ocupado = 0.
  - Internal state: espera = 0, all synchronizer and debounce state = 0, ultimo = 1.
- Reset is asserted asynchronously; release is synchronous to clock.
- Reset mid-hold-off or with requests pending discards everything.
- A button held through reset release is seen as a new press: nivel starts at 0, so pendente sets after debounce.
- Latency for a raw rise present before edge k:
  - nivel[i] rises at edge k+1+DEBOUNCE_CICLOS.
  - pendente[i] rises at edge k+2+DEBOUNCE_CICLOS.
  - The grant (concedido, LED toggle, ocupado=1) occurs at edge k+3+DEBOUNCE_CICLOS if idle.
- After a grant at edge g:
  - ocupado is high for exactly HOLDOFF_CICLOS cycles and falls at edge g+HOLDOFF_CICLOS.
  - The earliest next grant is at edge g+HOLDOFF_CICLOS+1.
- All outputs are registered. concedido is never high in two consecutive cycles.

## Test plan
All scenarios use DEBOUNCE_CICLOS=4 and HOLDOFF_CICLOS=3.
- **Reset:** assert reset_n=0 mid-operation -> immediately ledVerde=1, ledVermelho=0, pendente=00, concedido=00, ocupado=0.
- **Single press:** botao[0] rises before edge k and is held -> pendente[0]=1 at k+6; concedido=01 at k+7 with ledVerde=0, ledVermelho=1; ocupado high for edges k+7..k+9, low at k+10.
- **Glitch rejection:** botao[1] high for 3 cycles, then low -> pendente stays 00 and the LEDs do not change; 4-cycle pulse -> pendente[1] sets.
- **Tie:** both buttons rise in the same cycle after reset -> concedido=01 at k+7, concedido=10 at k+11 (hold-off 3 plus 1); LED ends in VERDE after two toggles.
- **Round-robin fairness:** channel 0 re-requests continuously while channel 1 is pending -> grants alternate 01, 10, 01, ... at 4-cycle spacing; no channel is served twice in a row while the other waits.
- **Set-wins race:** force a channel 0 rising edge on the cycle of its own grant -> pendente[0] stays 1 and is served again at grant+4.

Source files
------------

// File: rtl/arbitro_leds.sv
// Two-button front end for the green/red LED toggle: per-channel sync, debounce and
// sticky request, then a round-robin grant followed by a hold-off window.
module arbitro_leds #(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int HOLDOFF_CICLOS  = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] botao,
   output logic       ledVerde,
   output logic       ledVermelho,
   output logic [1:0] concedido,
   output logic [1:0] pendente,
   output logic       ocupado
);

   localparam int DW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS + 1) : 1;
   localparam int HW = (HOLDOFF_CICLOS > 1) ? $clog2(HOLDOFF_CICLOS + 1) : 1;

   typedef enum logic {VERDE = 1'b0, VERMELHO = 1'b1} estado_t;

   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         nivel_q, nivel_d;
   logic [1:0]         nivel_ant_q;
   logic [1:0][DW-1:0] cnt_q, cnt_d;
   logic [1:0]         pend_q, pend_d;
   logic [HW-1:0]      espera_q, espera_d;
   logic               ultimo_q, ultimo_d;
   estado_t            estado_q, estado_d;
   logic [1:0]         conc_q, conc_d;
   logic               ocup_q, ocup_d;
   logic               verde_q, verde_d;
   logic               vermelho_q, vermelho_d;
   logic [1:0]         sobe;
   logic [1:0]         gnt;

   always_comb begin
      nivel_d = nivel_q;
      cnt_d   = cnt_q;
      for (int unsigned i = 0; i < 2; i++) begin
         if (sync2_q[i] != nivel_q[i]) begin
            if (cnt_q[i] == DW'(DEBOUNCE_CICLOS - 1)) begin
               nivel_d[i] = sync2_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            cnt_d[i] = '0;
         end
      end

      sobe = nivel_q & ~nivel_ant_q;

      // On a tie the channel not served last wins
      gnt = '0;
      if (espera_q == '0 && pend_q != '0) begin
         if (pend_q == 2'b11) gnt = ultimo_q ? 2'b01 : 2'b10;
         else                 gnt = pend_q;
      end

      // A new rising edge overrides the clear of the channel being served
      pend_d   = (pend_q & ~gnt) | sobe;
      ultimo_d = ultimo_q;
      estado_d = estado_q;
      espera_d = espera_q;
      if (gnt != '0) begin
         ultimo_d = gnt[1];
         estado_d = (estado_q == VERDE) ? VERMELHO : VERDE;
         espera_d = HW'(HOLDOFF_CICLOS);
      end else if (espera_q != '0) begin
         espera_d = espera_q - 1'b1;
      end

      conc_d     = gnt;
      ocup_d     = (espera_d != '0);
      verde_d    = (estado_d == VERDE);
      vermelho_d = (estado_d == VERMELHO);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         nivel_q     <= '0;
         nivel_ant_q <= '0;
         cnt_q       <= '0;
         pend_q      <= '0;
         espera_q    <= '0;
         ultimo_q    <= 1'b1;
         estado_q    <= VERDE;
         conc_q      <= '0;
         ocup_q      <= 1'b0;
         verde_q     <= 1'b1;
         vermelho_q  <= 1'b0;
      end else begin
         sync1_q     <= botao;
         sync2_q     <= sync1_q;
         nivel_q     <= nivel_d;
         nivel_ant_q <= nivel_q;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         espera_q    <= espera_d;
         ultimo_q    <= ultimo_d;
         estado_q    <= estado_d;
         conc_q      <= conc_d;
         ocup_q      <= ocup_d;
         verde_q     <= verde_d;
         vermelho_q  <= vermelho_d;
      end
   end

   assign ledVerde    = verde_q;
   assign ledVermelho = vermelho_q;
   assign concedido   = conc_q;
   assign pendente    = pend_q;
   assign ocupado     = ocup_q;

endmodule

// File: tb/tb_arbitro_leds.sv
// Scoreboard bench for arbitro_leds: directed presses push expected grants,
// monitors pop and compare whenever a grant pulse appears.
module tb_arbitro_leds;

   logic       clock;
   logic       reset_n;
   logic [1:0] botao, botao_b;
   logic       verde_a, vermelho_a, ocup_a;
   logic [1:0] conc_a, pend_a;
   logic       verde_b, vermelho_b, ocup_b;
   logic [1:0] conc_b, pend_b;

   int ciclo = 0;
   int pass  = 0;
   int total = 0;

   typedef struct {
      int         ciclo;
      logic [1:0] g;
      logic       verde;
   } exp_t;

   exp_t fila_a[$];
   exp_t fila_b[$];
   exp_t ea, eb;

   arbitro_leds #(.DEBOUNCE_CICLOS(4), .HOLDOFF_CICLOS(3)) u_dut (
      .clock(clock), .reset_n(reset_n), .botao(botao),
      .ledVerde(verde_a), .ledVermelho(vermelho_a),
      .concedido(conc_a), .pendente(pend_a), .ocupado(ocup_a)
   );

   // Short debounce makes a rising edge coincide with the channel's own grant
   arbitro_leds #(.DEBOUNCE_CICLOS(1), .HOLDOFF_CICLOS(3)) u_race (
      .clock(clock), .reset_n(reset_n), .botao(botao_b),
      .ledVerde(verde_b), .ledVermelho(vermelho_b),
      .concedido(conc_b), .pendente(pend_b), .ocupado(ocup_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) ciclo <= ciclo + 1;

   task automatic chk(input string nome, input int act, input int exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, act, exp, ciclo);
   endtask

   task automatic wait_ciclo(input int t);
      while (ciclo < t) @(negedge clock);
   endtask

   always @(negedge clock) begin
      if (reset_n && conc_a != 2'b00) begin
         if (fila_a.size() == 0) begin
            chk("a_unexpected_grant", conc_a, 0);
         end else begin
            ea = fila_a.pop_front();
            chk("a_grant_cycle", ciclo, ea.ciclo);
            chk("a_grant_chan", conc_a, ea.g);
            chk("a_led_verde", verde_a, ea.verde);
            chk("a_led_vermelho", vermelho_a, !ea.verde);
         end
      end
      if (reset_n && conc_b != 2'b00) begin
         if (fila_b.size() == 0) begin
            chk("b_unexpected_grant", conc_b, 0);
         end else begin
            eb = fila_b.pop_front();
            chk("b_grant_cycle", ciclo, eb.ciclo);
            chk("b_grant_chan", conc_b, eb.g);
            chk("b_led_verde", verde_b, eb.verde);
            chk("b_led_vermelho", vermelho_b, !eb.verde);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d", ciclo);
      $fatal(1);
   end

   initial begin
      int c, k, r;
      reset_n = 1'b0;
      botao   = 2'b00;
      botao_b = 2'b00;
      repeat (3) @(negedge clock);
      chk("rst_verde", verde_a, 1);
      chk("rst_vermelho", vermelho_a, 0);
      chk("rst_pend", pend_a, 0);
      chk("rst_conc", conc_a, 0);
      chk("rst_ocup", ocup_a, 0);
      chk("rst_b_verde", verde_b, 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Single press on channel 0
      c = ciclo; k = c + 1;
      botao = 2'b01;
      fila_a.push_back('{k + 7, 2'b01, 1'b0});
      wait_ciclo(k + 5); chk("single_pend_k5", pend_a, 0);
      wait_ciclo(k + 6); chk("single_pend_k6", pend_a, 1);
      wait_ciclo(k + 7); chk("single_ocup_k7", ocup_a, 1);
      wait_ciclo(k + 9); chk("single_ocup_k9", ocup_a, 1);
      wait_ciclo(k + 10);
      chk("single_ocup_k10", ocup_a, 0);
      chk("single_pend_k10", pend_a, 0);
      botao = 2'b00;
      wait_ciclo(ciclo + 12);

      // 3-cycle glitch on channel 1 is rejected
      c = ciclo;
      botao = 2'b10;
      repeat (3) @(negedge clock);
      botao = 2'b00;
      wait_ciclo(c + 14);
      chk("glitch_pend", pend_a, 0);
      chk("glitch_led", verde_a, 0);

      // 4-cycle pulse on channel 1 is accepted
      c = ciclo; k = c + 1;
      botao = 2'b10;
      fila_a.push_back('{k + 7, 2'b10, 1'b1});
      repeat (4) @(negedge clock);
      botao = 2'b00;
      wait_ciclo(k + 6); chk("pulse4_pend_k6", pend_a, 2);
      wait_ciclo(k + 8); chk("pulse4_pend_k8", pend_a, 0);
      wait_ciclo(k + 14);

      // Reset during hold-off
      c = ciclo; k = c + 1;
      botao = 2'b01;
      fila_a.push_back('{k + 7, 2'b01, 1'b0});
      wait_ciclo(k + 8);
      chk("pre_rst_ocup", ocup_a, 1);
      chk("pre_rst_verde", verde_a, 0);
      botao   = 2'b00;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_verde", verde_a, 1);
      chk("mid_rst_vermelho", vermelho_a, 0);
      chk("mid_rst_pend", pend_a, 0);
      chk("mid_rst_conc", conc_a, 0);
      chk("mid_rst_ocup", ocup_a, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Tie right after reset: channel 0 first
      c = ciclo; k = c + 1;
      botao = 2'b11;
      fila_a.push_back('{k + 7, 2'b01, 1'b0});
      fila_a.push_back('{k + 11, 2'b10, 1'b1});
      wait_ciclo(k + 6); chk("tie_pend_k6", pend_a, 3);
      wait_ciclo(k + 7); chk("tie_pend_k7", pend_a, 2);
      wait_ciclo(k + 12);
      chk("tie_led_end", verde_a, 1);
      chk("tie_pend_end", pend_a, 0);
      botao = 2'b00;
      wait_ciclo(ciclo + 12);

      // Both channels re-request every 8 cycles: grants alternate every 4
      c = ciclo; k = c + 1;
      for (int n = 0; n < 6; n++)
         fila_a.push_back('{k + 7 + 4 * n, (n % 2 == 0) ? 2'b01 : 2'b10, (n % 2 == 0) ? 1'b0 : 1'b1});
      for (int p = 0; p < 3; p++) begin
         botao = 2'b11;
         repeat (4) @(negedge clock);
         botao = 2'b00;
         repeat (4) @(negedge clock);
      end
      wait_ciclo(k + 30);
      chk("rr_pend_end", pend_a, 0);
      chk("rr_ocup_end", ocup_a, 0);

      // Set-wins race on the short-debounce instance
      c = ciclo; r = c + 1;
      fila_b.push_back('{r + 4, 2'b10, 1'b0});
      fila_b.push_back('{r + 8, 2'b01, 1'b1});
      fila_b.push_back('{r + 12, 2'b01, 1'b0});
      botao_b = 2'b10;
      @(negedge clock); botao_b = 2'b11;
      @(negedge clock);
      @(negedge clock); botao_b = 2'b10;
      @(negedge clock);
      @(negedge clock); botao_b = 2'b11;
      wait_ciclo(r + 4); chk("race_pend_r4", pend_b, 1);
      wait_ciclo(r + 8); chk("race_pend_held", pend_b, 1);
      wait_ciclo(r + 12); chk("race_pend_r12", pend_b, 0);
      botao_b = 2'b00;
      wait_ciclo(ciclo + 8);

      chk("fila_a_empty", fila_a.size(), 0);
      chk("fila_b_empty", fila_b.size(), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
